sdf_fft_sequencer: RTL and testbench
====================================

# sdf_fft_sequencer

Parametrised stage sequencer for the single-path delay-feedback (SDF) FFT/IFFT pipeline. It accepts a frame start through a ready/start handshake and steps a one-hot stage-enable through all log2(NFFT) butterfly stages, holding each stage for its data length plus a configurable pipeline slack. It then streams an NFFT-cycle output-valid window with an output index, and tags each frame as forward or inverse. It sits between the correlation top-level control and the SDF stage chain, and is shared by the forward-FFT and IFFT instances.

## Interface
- NFFT, 128: transform size; power of two, ≥ 4.
- STAGE_LATENCY, 3: extra cycles each stage is held beyond its data length (butterfly and twiddle pipeline slack); 0–15.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  frame start request; accepted on a clk edge where start && ready.
- inverse  in  1  mode for the frame; sampled with an accepted start (1 = IFFT).
- abort  in  1  synchronous abort; highest priority.
- ready  out  1  sequencer can accept start.
- stage_en  out  log2(NFFT)  one-hot active stage; bit k = stage k; 0 when no stage is running.
- stage_idx  out  log2(log2(NFFT))+1  binary index of the active stage; 0 when idle.
- frame_inverse  out  1  latched mode of the frame currently in the stages.
- end_fft  out  1  one-cycle pulse on the first output-valid cycle.
- data_valid  out  1  high for exactly NFFT cycles per frame.
- out_idx  out  log2(NFFT)  output sample index 0..NFFT-1 while data_valid; 0 otherwise.
- out_inverse  out  1  mode tag of the frame being streamed.

## Operation
- All outputs are registered. Reset values: ready=1; every other output 0. Counters and state registers also reset to 0 / IDLE.
- Stage sequencer states:
  - IDLE: waits for start && ready. On acceptance, moves to STAGE with stage 0, counter 0, and frame_inverse=inverse.
  - STAGE: stage k lasts L(k) = (NFFT>>(k+1)) + STAGE_LATENCY + 1 cycles. The counter runs 0..L(k)-1.
    - At terminal count with k < log2(NFFT)-1: advance to stage k+1 and clear the counter. The stage_en bit shifts left with no gap cycle.
    - At terminal count of the last stage: hand the frame to the output streamer and return to IDLE.
- Output streamer states (sub-block):
  - IDLE: waits for a handoff.
  - STREAM: data_valid=1 and out_idx counts 0..NFFT-1. end_fft=1 only when out_idx=0. After out_idx=NFFT-1, returns to IDLE and clears data_valid and out_idx.
- out_inverse is copied from frame_inverse at handoff and held through STREAM.
- ready=1 only when both the sequencer and the streamer are in IDLE (see Configuration). start while ready=0 is ignored, not queued.
- abort: on the next edge both state machines go to IDLE and all outputs return to reset values. No end_fft is generated. abort and start in the same cycle: abort wins and start is dropped.
- Reset mid-frame: immediate return to reset values; no partial pulses afterwards.
- Counter width: $clog2(NFFT/2 + STAGE_LATENCY + 1). No wrap-around is possible within legal parameters.

## Timing
- Start accepted at edge t: stage_en=1 visible from t+1.
- Stage 0 occupies cycles t+1 .. t+L(0). Each subsequent stage begins on the cycle immediately after the previous one ends.
- Total stage time S = Σ L(k) = NFFT − 1 + log2(NFFT)·(STAGE_LATENCY+1).
- end_fft and the first data_valid occur at t+S+1. data_valid stays high for cycles t+S+1 .. t+S+NFFT.
- Without overlap, ready returns at t+S+NFFT+1, and the earliest next start is accepted on that edge.

## Configuration
- SDF_SEQ_OVERLAP_EN defined: ready = sequencer in IDLE, independent of the streamer. A new frame may start its stages while the previous frame streams.
  - Because S ≥ NFFT, the previous stream always finishes before the new handoff. An assertion checks that the streamer is IDLE at every handoff.
  - Back-to-back frames then cost S+1 cycles each.
- Undefined: ready requires both machines idle, as described in Operation.

## Structure
- Shared package sdf_fft_pkg holds:
  - the sequencer and streamer state enums;
  - the constant LOG2N = $clog2(NFFT);
  - the function stage_len(k) = (NFFT>>(k+1)) + STAGE_LATENCY + 1.
- One sub-module, sdf_out_streamer: owns data_valid, end_fft, out_idx and out_inverse. It takes a handoff pulse and a mode bit as inputs.

## Test plan
- NFFT=8, STAGE_LATENCY=3, start at cycle 0:
  - stage_en=001 on cycles 1–8, 010 on cycles 9–14, 100 on cycles 15–19;
  - end_fft at cycle 20;
  - data_valid on cycles 20–27 with out_idx 0..7;
  - ready=1 again at cycle 28.
- Same configuration with inverse=1 at start and inverse toggled during the frame: frame_inverse and out_inverse stay 1 throughout.
- abort at cycle 10: stage_en=0 and ready=1 from cycle 11. No end_fft or data_valid ever appears for that frame.
- start held high continuously, no overlap: exactly one frame every 28 cycles (S=19 plus NFFT=8 plus 1).
- SDF_SEQ_OVERLAP_EN defined, start held high: frames are accepted every 20 cycles, data_valid windows do not overlap, and the assertion never fires.
- rst asserted at cycle 22 (mid-stream), released at cycle 24: all outputs are at reset values from the assertion onward, and a new start at cycle 25 gives stage_en=001 at cycle 26.

Source files
------------

// File: rtl/sdf_fft_pkg.sv
// Shared definitions for the SDF FFT stage sequencer and its output streamer:
// state enums, the default stage count and the per-stage hold length.
package sdf_fft_pkg;

    localparam int DEFAULT_NFFT          = 128;
    localparam int DEFAULT_STAGE_LATENCY = 3;
    localparam int LOG2N                 = $clog2(DEFAULT_NFFT);

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_STAGE = 1'b1
    } seq_state_t;

    typedef enum logic [0:0] {
        STRM_IDLE   = 1'b0,
        STRM_STREAM = 1'b1
    } strm_state_t;

    // Stage k handles NFFT>>(k+1) samples and is held a little longer so the
    // butterfly and twiddle pipeline can drain before the next stage starts.
    function automatic int stage_len(input int k,
                                     input int nfft    = DEFAULT_NFFT,
                                     input int latency = DEFAULT_STAGE_LATENCY);
        return (nfft >> (k + 1)) + latency + 1;
    endfunction

endpackage

// File: rtl/sdf_fft_sequencer_if.sv
// Handshake and status bundle between the correlation control (master) and
// the SDF stage sequencer (slave).
interface sdf_fft_sequencer_if #(
    parameter int NFFT = 128
);
    localparam int LOG2N_W = $clog2(NFFT);
    localparam int SIDX_W  = $clog2(LOG2N_W) + 1;

    logic               start;
    logic               inverse;
    logic               abort;
    logic               ready;
    logic [LOG2N_W-1:0] stage_en;
    logic [SIDX_W-1:0]  stage_idx;
    logic               frame_inverse;
    logic               end_fft;
    logic               data_valid;
    logic [LOG2N_W-1:0] out_idx;
    logic               out_inverse;

    modport master (
        output start, inverse, abort,
        input  ready, stage_en, stage_idx, frame_inverse,
               end_fft, data_valid, out_idx, out_inverse
    );

    modport slave (
        input  start, inverse, abort,
        output ready, stage_en, stage_idx, frame_inverse,
               end_fft, data_valid, out_idx, out_inverse
    );

endinterface

// File: rtl/sdf_fft_sequencer_streamer.sv
// sdf_out_streamer: after the last butterfly stage finishes, streams an
// NFFT-cycle output-valid window with a running sample index and the frame's
// mode tag. Optional macro SDF_SEQ_OVERLAP_EN adds a check that no handoff
// arrives while a previous frame is still streaming.
module sdf_out_streamer
    import sdf_fft_pkg::*;
#(
    parameter int NFFT = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    abort,
    input  logic                    handoff,
    input  logic                    mode,
    output logic                    data_valid,
    output logic                    end_fft,
    output logic [$clog2(NFFT)-1:0] out_idx,
    output logic                    out_inverse,
    output logic                    busy_next
);

    localparam int               IDX_W    = $clog2(NFFT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

    strm_state_t      state;
    strm_state_t      state_n;
    logic [IDX_W-1:0] idx_n;
    logic             dv_n;
    logic             end_n;
    logic             inv_n;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STRM_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: a handoff opens the window, the last index closes it
    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = STRM_IDLE;
        end else begin
            case (state)
                STRM_IDLE:   if (handoff) state_n = STRM_STREAM;
                STRM_STREAM: if (out_idx == LAST_IDX) state_n = STRM_IDLE;
                default:     state_n = STRM_IDLE;
            endcase
        end
    end

    // Next output values; the mode tag is captured only when a window opens
    always_comb begin
        idx_n = '0;
        dv_n  = (state_n == STRM_STREAM);
        end_n = (state == STRM_IDLE) && (state_n == STRM_STREAM);
        inv_n = out_inverse;
        if (abort) begin
            inv_n = 1'b0;
        end else begin
            if (state == STRM_IDLE && handoff) begin
                inv_n = mode;
            end
            if (state == STRM_STREAM && state_n == STRM_STREAM) begin
                idx_n = out_idx + IDX_W'(1);
            end
        end
        busy_next = (state_n == STRM_STREAM);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid  <= 1'b0;
            end_fft     <= 1'b0;
            out_idx     <= '0;
            out_inverse <= 1'b0;
        end else begin
            data_valid  <= dv_n;
            end_fft     <= end_n;
            out_idx     <= idx_n;
            out_inverse <= inv_n;
        end
    end

`ifdef SDF_SEQ_OVERLAP_EN
    // With overlapping frames a new handoff must never land on an active stream
    always @(posedge clk) begin
        if (!rst && !abort && handoff) begin
            assert (state == STRM_IDLE);
        end
    end
`endif

endmodule

// File: rtl/sdf_fft_sequencer.sv
// sdf_fft_sequencer: steps a one-hot stage enable through all log2(NFFT)
// SDF butterfly stages, then hands the frame to the output streamer.
// Optional macro SDF_SEQ_OVERLAP_EN lets a new frame enter the stages while
// the previous one is still streaming out.
module sdf_fft_sequencer
    import sdf_fft_pkg::*;
#(
    parameter int NFFT          = 128,
    parameter int STAGE_LATENCY = 3
) (
    input  logic                clk,
    input  logic                rst,
    sdf_fft_sequencer_if.slave  bus
);

    localparam int                N_STAGES   = $clog2(NFFT);
    localparam int                SIDX_W     = $clog2(N_STAGES) + 1;
    localparam int                CNT_W      = $clog2(NFFT / 2 + STAGE_LATENCY + 1);
    localparam logic [SIDX_W-1:0] LAST_STAGE = SIDX_W'(N_STAGES - 1);

    seq_state_t          state;
    seq_state_t          state_n;
    logic [SIDX_W-1:0]   stage;
    logic [SIDX_W-1:0]   stage_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic                terminal;
    logic                handoff;
    logic                finv_n;
    logic                ready_n;
    logic                strm_busy_n;
    logic [N_STAGES-1:0] stage_en_n;
    logic [SIDX_W-1:0]   stage_idx_n;

    // State register together with the active stage and its cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEQ_IDLE;
            stage <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            stage <= stage_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: accept a frame, advance stages at terminal count, hand off after the last
    always_comb begin
        state_n  = state;
        stage_n  = stage;
        cnt_n    = cnt;
        handoff  = 1'b0;
        finv_n   = bus.frame_inverse;
        terminal = (int'(cnt) == stage_len(int'(stage), NFFT, STAGE_LATENCY) - 1);
        if (bus.abort) begin
            state_n = SEQ_IDLE;
            stage_n = '0;
            cnt_n   = '0;
            finv_n  = 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (bus.start && bus.ready) begin
                        state_n = SEQ_STAGE;
                        stage_n = '0;
                        cnt_n   = '0;
                        finv_n  = bus.inverse;
                    end
                end
                SEQ_STAGE: begin
                    if (terminal) begin
                        cnt_n = '0;
                        if (stage == LAST_STAGE) begin
                            state_n = SEQ_IDLE;
                            stage_n = '0;
                            handoff = 1'b1;
                        end else begin
                            stage_n = stage + SIDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = SEQ_IDLE;
                    stage_n = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Next output values derived from where the machines are heading
    always_comb begin
        stage_en_n  = '0;
        stage_idx_n = '0;
        if (state_n == SEQ_STAGE) begin
            stage_en_n  = N_STAGES'(1) << stage_n;
            stage_idx_n = stage_n;
        end
`ifdef SDF_SEQ_OVERLAP_EN
        ready_n = (state_n == SEQ_IDLE);
`else
        ready_n = (state_n == SEQ_IDLE) && !strm_busy_n;
`endif
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ready         <= 1'b1;
            bus.stage_en      <= '0;
            bus.stage_idx     <= '0;
            bus.frame_inverse <= 1'b0;
        end else begin
            bus.ready         <= ready_n;
            bus.stage_en      <= stage_en_n;
            bus.stage_idx     <= stage_idx_n;
            bus.frame_inverse <= finv_n;
        end
    end

    sdf_out_streamer #(
        .NFFT (NFFT)
    ) u_streamer (
        .clk         (clk),
        .rst         (rst),
        .abort       (bus.abort),
        .handoff     (handoff),
        .mode        (bus.frame_inverse),
        .data_valid  (bus.data_valid),
        .end_fft     (bus.end_fft),
        .out_idx     (bus.out_idx),
        .out_inverse (bus.out_inverse),
        .busy_next   (strm_busy_n)
    );

endmodule

// File: tb/tb_sdf_fft_sequencer.sv
// Testbench for sdf_fft_sequencer (NFFT=8, STAGE_LATENCY=3). A frame-level
// timing model predicts every output from the acceptance cycle of each frame.
module tb_sdf_fft_sequencer;

    localparam int NFFT   = 8;
    localparam int LAT    = 3;
    localparam int NST    = 3;
    localparam int SIDX_W = 3;
    localparam int S      = NFFT - 1 + NST * (LAT + 1);
`ifdef SDF_SEQ_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sdf_fft_sequencer_if #(.NFFT(NFFT)) bus ();

    sdf_fft_sequencer #(
        .NFFT          (NFFT),
        .STAGE_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model: acceptance cycle of the frame in the stages / of the frame streaming
    int m_a = -1;
    int m_s = -1;
    bit m_amode;
    bit m_smode;

    logic              exp_ready;
    logic [NST-1:0]    exp_en;
    logic [SIDX_W-1:0] exp_sidx;
    logic              exp_finv;
    logic              exp_dv;
    logic              exp_end;
    logic [NST-1:0]    exp_oidx;
    logic              exp_oinv;
    bit                stage_act;
    bit                strm_act;

    function automatic int len_of(int k);
        return NFFT / (2 ** (k + 1)) + LAT + 1;
    endfunction

    function automatic void model_eval();
        int d;
        int lo;
        exp_en    = '0;
        exp_sidx  = '0;
        exp_dv    = 1'b0;
        exp_end   = 1'b0;
        exp_oidx  = '0;
        stage_act = 1'b0;
        strm_act  = 1'b0;
        exp_finv  = m_amode;
        exp_oinv  = m_smode;
        if (m_a >= 0) begin
            d  = cyc - m_a;
            lo = 0;
            stage_act = 1'b1;
            for (int k = 0; k < NST; k++) begin
                if (d >= lo && d < lo + len_of(k)) begin
                    exp_en   = NST'(1) << k;
                    exp_sidx = SIDX_W'(k);
                end
                lo += len_of(k);
            end
        end
        if (m_s >= 0) begin
            d        = cyc - m_s - S;
            strm_act = 1'b1;
            exp_dv   = 1'b1;
            exp_oidx = NST'(d);
            exp_end  = (d == 0);
        end
        exp_ready = (m_a < 0) && (OVL || m_s < 0);
    endfunction

    function automatic void model_clear();
        m_a = -1;
        m_s = -1;
        m_amode = 1'b0;
        m_smode = 1'b0;
        model_eval();
    endfunction

    task automatic applyStimulus(input bit s, input bit inv, input bit ab);
        bus.start   = s;
        bus.inverse = inv;
        bus.abort   = ab;
    endtask

    // advance one clock, update the model from the inputs seen at the edge
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst || bus.abort) begin
            model_clear();
        end else begin
            if (m_s >= 0 && cyc - m_s - S >= NFFT) m_s = -1;
            if (m_a >= 0 && cyc - m_a >= S) begin
                m_s     = m_a;
                m_smode = m_amode;
                m_a     = -1;
            end
            if (bus.start && exp_ready) begin
                m_a     = cyc;
                m_amode = bus.inverse;
            end
            model_eval();
        end
        #1;
    endtask

    task automatic drain();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < S + NFFT + 4; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        model_clear();
        for (int i = 0; i < 3; i++) tick();
        n_cmp += 8;
        if (bus.ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %0h, want 1", bus.ready); end
        if (bus.stage_en !== '0) begin n_bad++; $display("[TB] FAIL reset_stage_en: got %0h, want 0", bus.stage_en); end
        if (bus.stage_idx !== '0) begin n_bad++; $display("[TB] FAIL reset_stage_idx: got %0h, want 0", bus.stage_idx); end
        if (bus.frame_inverse !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_frame_inverse: got %0h, want 0", bus.frame_inverse); end
        if (bus.end_fft !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_end_fft: got %0h, want 0", bus.end_fft); end
        if (bus.data_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_data_valid: got %0h, want 0", bus.data_valid); end
        if (bus.out_idx !== '0) begin n_bad++; $display("[TB] FAIL reset_out_idx: got %0h, want 0", bus.out_idx); end
        if (bus.out_inverse !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_inverse: got %0h, want 0", bus.out_inverse); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int c0;
        int end_at;
        int dv_cnt;
        bit inv;
        inv    = 1'($urandom);
        end_at = -1;
        dv_cnt = 0;
        c0     = cyc;
        applyStimulus(1'b1, inv, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < S + NFFT + 6; i++) begin
            n_cmp += 6;
            if (bus.stage_en !== exp_en) begin n_bad++; $display("[TB] FAIL single_stage_en cyc=%0d: got %0h, want %0h", cyc, bus.stage_en, exp_en); end
            if (bus.stage_idx !== exp_sidx) begin n_bad++; $display("[TB] FAIL single_stage_idx cyc=%0d: got %0h, want %0h", cyc, bus.stage_idx, exp_sidx); end
            if (bus.data_valid !== exp_dv) begin n_bad++; $display("[TB] FAIL single_data_valid cyc=%0d: got %0h, want %0h", cyc, bus.data_valid, exp_dv); end
            if (bus.out_idx !== exp_oidx) begin n_bad++; $display("[TB] FAIL single_out_idx cyc=%0d: got %0h, want %0h", cyc, bus.out_idx, exp_oidx); end
            if (bus.end_fft !== exp_end) begin n_bad++; $display("[TB] FAIL single_end_fft cyc=%0d: got %0h, want %0h", cyc, bus.end_fft, exp_end); end
            if (bus.ready !== exp_ready) begin n_bad++; $display("[TB] FAIL single_ready cyc=%0d: got %0h, want %0h", cyc, bus.ready, exp_ready); end
            if (stage_act) begin
                n_cmp++;
                if (bus.frame_inverse !== exp_finv) begin n_bad++; $display("[TB] FAIL single_frame_inverse cyc=%0d: got %0h, want %0h", cyc, bus.frame_inverse, exp_finv); end
            end
            if (strm_act) begin
                n_cmp++;
                if (bus.out_inverse !== exp_oinv) begin n_bad++; $display("[TB] FAIL single_out_inverse cyc=%0d: got %0h, want %0h", cyc, bus.out_inverse, exp_oinv); end
            end
            if (bus.end_fft === 1'b1 && end_at < 0) end_at = cyc - c0;
            if (bus.data_valid === 1'b1) dv_cnt++;
            tick();
        end
        n_cmp += 2;
        if (end_at != S + 1) begin n_bad++; $display("[TB] FAIL single_end_offset: got %0d, want %0d", end_at, S + 1); end
        if (dv_cnt != NFFT) begin n_bad++; $display("[TB] FAIL single_dv_length: got %0d, want %0d", dv_cnt, NFFT); end
    endtask

    task automatic test_inverse_hold();
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < S + NFFT + 2; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'b0);
            if (stage_act) begin
                n_cmp++;
                if (bus.frame_inverse !== 1'b1) begin n_bad++; $display("[TB] FAIL hold_frame_inverse cyc=%0d: got %0h, want 1", cyc, bus.frame_inverse); end
            end
            if (strm_act) begin
                n_cmp++;
                if (bus.out_inverse !== 1'b1) begin n_bad++; $display("[TB] FAIL hold_out_inverse cyc=%0d: got %0h, want 1", cyc, bus.out_inverse); end
            end
            tick();
        end
    endtask

    task automatic test_abort();
        int dly;
        int dv_seen;
        for (int r = 0; r < 3; r++) begin
            dly     = (r == 0) ? 10 : int'($urandom_range(3, S + NFFT - 2));
            dv_seen = 0;
            applyStimulus(1'b1, 1'($urandom), 1'b0);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0);
            for (int i = 1; i < dly; i++) tick();
            applyStimulus(r == 1, 1'b1, 1'b1);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < S + NFFT + 2; i++) begin
                n_cmp += 4;
                if (bus.stage_en !== exp_en) begin n_bad++; $display("[TB] FAIL abort_stage_en cyc=%0d: got %0h, want %0h", cyc, bus.stage_en, exp_en); end
                if (bus.ready !== exp_ready) begin n_bad++; $display("[TB] FAIL abort_ready cyc=%0d: got %0h, want %0h", cyc, bus.ready, exp_ready); end
                if (bus.data_valid !== exp_dv) begin n_bad++; $display("[TB] FAIL abort_data_valid cyc=%0d: got %0h, want %0h", cyc, bus.data_valid, exp_dv); end
                if (bus.end_fft !== exp_end) begin n_bad++; $display("[TB] FAIL abort_end_fft cyc=%0d: got %0h, want %0h", cyc, bus.end_fft, exp_end); end
                if (bus.data_valid === 1'b1 || bus.end_fft === 1'b1) dv_seen++;
                tick();
            end
            n_cmp++;
            if (dv_seen != 0) begin n_bad++; $display("[TB] FAIL abort_no_output: got %0d, want 0", dv_seen); end
        end
    endtask

    task automatic test_back_to_back();
        int ends_dut;
        int ends_exp;
        ends_dut = 0;
        ends_exp = 0;
        for (int i = 0; i < 3 * (S + NFFT + 1) + 5; i++) begin
            applyStimulus(1'b1, 1'($urandom), 1'b0);
            tick();
            n_cmp += 5;
            if (bus.stage_en !== exp_en) begin n_bad++; $display("[TB] FAIL b2b_stage_en cyc=%0d: got %0h, want %0h", cyc, bus.stage_en, exp_en); end
            if (bus.ready !== exp_ready) begin n_bad++; $display("[TB] FAIL b2b_ready cyc=%0d: got %0h, want %0h", cyc, bus.ready, exp_ready); end
            if (bus.data_valid !== exp_dv) begin n_bad++; $display("[TB] FAIL b2b_data_valid cyc=%0d: got %0h, want %0h", cyc, bus.data_valid, exp_dv); end
            if (bus.out_idx !== exp_oidx) begin n_bad++; $display("[TB] FAIL b2b_out_idx cyc=%0d: got %0h, want %0h", cyc, bus.out_idx, exp_oidx); end
            if (bus.end_fft !== exp_end) begin n_bad++; $display("[TB] FAIL b2b_end_fft cyc=%0d: got %0h, want %0h", cyc, bus.end_fft, exp_end); end
            if (strm_act) begin
                n_cmp++;
                if (bus.out_inverse !== exp_oinv) begin n_bad++; $display("[TB] FAIL b2b_out_inverse cyc=%0d: got %0h, want %0h", cyc, bus.out_inverse, exp_oinv); end
            end
            if (bus.end_fft === 1'b1) ends_dut++;
            if (exp_end) ends_exp++;
        end
        n_cmp++;
        if (ends_dut != ends_exp) begin n_bad++; $display("[TB] FAIL b2b_frame_count: got %0d, want %0d", ends_dut, ends_exp); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) == 0, 1'($urandom), ($urandom % 64) == 0);
            tick();
            n_cmp += 7;
            if (bus.stage_en !== exp_en) begin n_bad++; $display("[TB] FAIL rand_stage_en cyc=%0d: got %0h, want %0h", cyc, bus.stage_en, exp_en); end
            if (bus.stage_idx !== exp_sidx) begin n_bad++; $display("[TB] FAIL rand_stage_idx cyc=%0d: got %0h, want %0h", cyc, bus.stage_idx, exp_sidx); end
            if (bus.ready !== exp_ready) begin n_bad++; $display("[TB] FAIL rand_ready cyc=%0d: got %0h, want %0h", cyc, bus.ready, exp_ready); end
            if (bus.data_valid !== exp_dv) begin n_bad++; $display("[TB] FAIL rand_data_valid cyc=%0d: got %0h, want %0h", cyc, bus.data_valid, exp_dv); end
            if (bus.out_idx !== exp_oidx) begin n_bad++; $display("[TB] FAIL rand_out_idx cyc=%0d: got %0h, want %0h", cyc, bus.out_idx, exp_oidx); end
            if (bus.end_fft !== exp_end) begin n_bad++; $display("[TB] FAIL rand_end_fft cyc=%0d: got %0h, want %0h", cyc, bus.end_fft, exp_end); end
            if (stage_act && bus.frame_inverse !== exp_finv) begin n_bad++; $display("[TB] FAIL rand_frame_inverse cyc=%0d: got %0h, want %0h", cyc, bus.frame_inverse, exp_finv); end
            if (strm_act) begin
                n_cmp++;
                if (bus.out_inverse !== exp_oinv) begin n_bad++; $display("[TB] FAIL rand_out_inverse cyc=%0d: got %0h, want %0h", cyc, bus.out_inverse, exp_oinv); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 22; i++) tick();
        n_cmp++;
        if (bus.data_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_streaming: got %0h, want 1", bus.data_valid); end
        rst = 1'b1;
        model_clear();
        #1;
        n_cmp += 6;
        if (bus.ready !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_ready: got %0h, want 1", bus.ready); end
        if (bus.stage_en !== '0) begin n_bad++; $display("[TB] FAIL midrst_stage_en: got %0h, want 0", bus.stage_en); end
        if (bus.data_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_data_valid: got %0h, want 0", bus.data_valid); end
        if (bus.end_fft !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_end_fft: got %0h, want 0", bus.end_fft); end
        if (bus.out_idx !== '0) begin n_bad++; $display("[TB] FAIL midrst_out_idx: got %0h, want 0", bus.out_idx); end
        if (bus.out_inverse !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_out_inverse: got %0h, want 0", bus.out_inverse); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        n_cmp += 2;
        if (bus.stage_en !== 3'b001) begin n_bad++; $display("[TB] FAIL midrst_restart_stage_en: got %0h, want 1", bus.stage_en); end
        if (bus.ready !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_restart_ready: got %0h, want 0", bus.ready); end
        for (int i = 0; i < S + NFFT + 2; i++) begin
            tick();
            n_cmp += 2;
            if (bus.data_valid !== exp_dv) begin n_bad++; $display("[TB] FAIL midrst_after_dv cyc=%0d: got %0h, want %0h", cyc, bus.data_valid, exp_dv); end
            if (bus.end_fft !== exp_end) begin n_bad++; $display("[TB] FAIL midrst_after_end cyc=%0d: got %0h, want %0h", cyc, bus.end_fft, exp_end); end
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        model_clear();
        test_reset();
        drain();
        test_single_frame();
        drain();
        test_single_frame();
        drain();
        test_inverse_hold();
        drain();
        test_abort();
        drain();
        test_back_to_back();
        drain();
        test_random();
        drain();
        test_reset_midstream();
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
